// File: rtl/au_seq_unit.sv
// au_seq_unit: clocked arithmetic unit with a GPR file and a special register
// (SGPR). One instruction at a time is accepted under a valid/ready handshake.
// MUL takes an extra pipeline stage. DIV is a restoring divider that produces
// one quotient bit per cycle and leaves the remainder in SGPR.
module au_seq_unit #(
    parameter int DW   = 16,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int IMMW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [AW-1:0]   rdst,
    input  logic [AW-1:0]   rsrc1,
    input  logic [AW-1:0]   rsrc2,
    input  logic            imm_mode,
    input  logic [IMMW-1:0] imm,
    output logic            done,
    output logic            err,
    output logic            flag_c,
    output logic            flag_z,
    output logic [DW-1:0]   sgpr,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    localparam logic [2:0] OP_MOVSGPR = 3'd0;
    localparam logic [2:0] OP_MOV     = 3'd1;
    localparam logic [2:0] OP_ADD     = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_MUL     = 3'd4;
    localparam logic [2:0] OP_DIV     = 3'd5;

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL2 = 2'd2,
        S_DIV  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Architectural state
    logic [DW-1:0] r_gpr [NREG];
    logic [DW-1:0] r_sgpr;
    logic          r_flag_c;
    logic          r_flag_z;
    logic          r_done;
    logic          r_err;

    // Instruction latched at accept; sources are read here so rdst may alias them
    logic [2:0]    r_op;
    logic [AW-1:0] r_rdst;
    logic          r_imm_mode;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;

    // Multiplier stage and divider working registers
    logic [2*DW-1:0] r_prod;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_rem;
    logic [CW-1:0]   r_cnt;

    // Combinational helpers
    logic            w_accept;
    logic [DW-1:0]   w_imm_ext;
    logic [DW-1:0]   w_b_in;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_diff;
    logic [2*DW-1:0] w_prod;
    logic [DW:0]     w_div_shift;
    logic [DW:0]     w_div_trial;
    logic            w_div_ge;
    logic [DW-1:0]   w_div_rem_nxt;
    logic [DW-1:0]   w_div_quo_nxt;

    // Writeback controls
    logic          w_we;
    logic [DW-1:0] w_wdata;
    logic          w_sgpr_we;
    logic [DW-1:0] w_sgpr_wdata;
    logic          w_c_we;
    logic          w_c_val;
    logic          w_fin;
    logic          w_fin_err;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_imm_ext = DW'(imm);
    assign w_b_in    = imm_mode ? w_imm_ext : r_gpr[rsrc2];

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = r_a - r_b;
    assign w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, r_b};

    // Restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor; a clear top bit means the subtraction fits.
    assign w_div_shift   = {r_rem, r_quo[DW-1]};
    assign w_div_trial   = w_div_shift - {1'b0, r_b};
    assign w_div_ge      = ~w_div_trial[DW];
    assign w_div_rem_nxt = w_div_ge ? w_div_trial[DW-1:0] : w_div_shift[DW-1:0];
    assign w_div_quo_nxt = {r_quo[DW-2:0], w_div_ge};

    assign in_ready = (r_state == S_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;
    assign sgpr     = r_sgpr;
    assign rd_data  = r_gpr[rd_addr];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                if (r_op == OP_MUL) begin
                    w_state_nxt = S_MUL2;
                end else if ((r_op == OP_DIV) && (r_b != {DW{1'b0}})) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL2: w_state_nxt = S_IDLE;
            S_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Retirement decode: what gets written, and whether done/err fire
    always_comb begin
        w_we         = 1'b0;
        w_wdata      = {DW{1'b0}};
        w_sgpr_we    = 1'b0;
        w_sgpr_wdata = {DW{1'b0}};
        w_c_we       = 1'b0;
        w_c_val      = 1'b0;
        w_fin        = 1'b0;
        w_fin_err    = 1'b0;
        case (r_state)
            S_EXEC: begin
                case (r_op)
                    OP_MOVSGPR: begin
                        w_we    = 1'b1;
                        w_wdata = r_sgpr;
                        w_fin   = 1'b1;
                    end
                    OP_MOV: begin
                        w_we    = 1'b1;
                        w_wdata = r_imm_mode ? r_b : r_a;
                        w_fin   = 1'b1;
                    end
                    OP_ADD: begin
                        w_we    = 1'b1;
                        w_wdata = w_sum[DW-1:0];
                        w_c_we  = 1'b1;
                        w_c_val = w_sum[DW];
                        w_fin   = 1'b1;
                    end
                    OP_SUB: begin
                        w_we    = 1'b1;
                        w_wdata = w_diff;
                        w_c_we  = 1'b1;
                        w_c_val = (r_a < r_b);
                        w_fin   = 1'b1;
                    end
                    OP_MUL: begin
                        w_fin = 1'b0;
                    end
                    OP_DIV: begin
                        if (r_b == {DW{1'b0}}) begin
                            w_fin     = 1'b1;
                            w_fin_err = 1'b1;
                        end else begin
                            w_fin = 1'b0;
                        end
                    end
                    default: begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end
                endcase
            end
            S_MUL2: begin
                w_we         = 1'b1;
                w_wdata      = r_prod[DW-1:0];
                w_sgpr_we    = 1'b1;
                w_sgpr_wdata = r_prod[2*DW-1:DW];
                w_fin        = 1'b1;
            end
            S_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_we         = 1'b1;
                    w_wdata      = w_div_quo_nxt;
                    w_sgpr_we    = 1'b1;
                    w_sgpr_wdata = w_div_rem_nxt;
                    w_fin        = 1'b1;
                end else begin
                    w_fin = 1'b0;
                end
            end
            default: begin
                w_fin = 1'b0;
            end
        endcase
    end

    // Operand capture at accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= 3'd0;
            r_rdst     <= {AW{1'b0}};
            r_imm_mode <= 1'b0;
            r_a        <= {DW{1'b0}};
            r_b        <= {DW{1'b0}};
        end else if (w_accept) begin
            r_op       <= op;
            r_rdst     <= rdst;
            r_imm_mode <= imm_mode;
            r_a        <= r_gpr[rsrc1];
            r_b        <= w_b_in;
        end
    end

    // Multiplier register and divider iteration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod <= {(2*DW){1'b0}};
            r_quo  <= {DW{1'b0}};
            r_rem  <= {DW{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else if (r_state == S_EXEC) begin
            r_prod <= w_prod;
            r_quo  <= r_a;
            r_rem  <= {DW{1'b0}};
            r_cnt  <= {CW{1'b0}};
        end else if (r_state == S_DIV) begin
            r_quo <= w_div_quo_nxt;
            r_rem <= w_div_rem_nxt;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= {DW{1'b0}};
            end
        end else if (w_we) begin
            r_gpr[r_rdst] <= w_wdata;
        end
    end

    // SGPR, flags and retirement pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sgpr   <= {DW{1'b0}};
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_fin;
            r_err  <= w_fin_err;
            if (w_sgpr_we) begin
                r_sgpr <= w_sgpr_wdata;
            end
            if (w_c_we) begin
                r_flag_c <= w_c_val;
            end
            if (w_we) begin
                r_flag_z <= (w_wdata == {DW{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_au_seq_unit.sv
// tb_au_seq_unit: directed and random instruction sequences for au_seq_unit,
// checked against an arithmetic reference model of the register file.
module tb_au_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic [4:0]  rsrc2;
    logic        imm_mode;
    logic [15:0] imm;
    logic        done;
    logic        err;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] sgpr;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;
    logic        m_c;
    logic        m_z;

    au_seq_unit #(.DW(16), .NREG(32), .AW(5), .IMMW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rdst(rdst), .rsrc1(rsrc1), .rsrc2(rsrc2),
        .imm_mode(imm_mode), .imm(imm), .done(done), .err(err),
        .flag_c(flag_c), .flag_z(flag_z), .sgpr(sgpr),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 16'd0;
        m_sgpr = 16'd0;
        m_c    = 1'b0;
        m_z    = 1'b0;
    endtask

    task automatic mwrite(input logic [4:0] d, input logic [15:0] v);
        m_gpr[d] = v;
        m_z      = (v == 16'd0);
    endtask

    // Architectural effect of one instruction, plus expected err and latency
    task automatic model_exec(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic im, input logic [15:0] iv,
                              output logic e_err, output int e_lat);
        logic [15:0] a;
        logic [15:0] b;
        int unsigned ua;
        int unsigned ub;
        int unsigned res;
        a  = m_gpr[s1];
        b  = im ? iv : m_gpr[s2];
        ua = int'(a);
        ub = int'(b);
        e_err = 1'b0;
        e_lat = 1;
        case (o)
            3'd0: mwrite(d, m_sgpr);
            3'd1: mwrite(d, im ? iv : a);
            3'd2: begin
                res = ua + ub;
                mwrite(d, 16'(res % 65536));
                m_c = (res >= 65536);
            end
            3'd3: begin
                res = (ua + 65536 - ub) % 65536;
                mwrite(d, 16'(res));
                m_c = (ua < ub);
            end
            3'd4: begin
                res = ua * ub;
                mwrite(d, 16'(res % 65536));
                m_sgpr = 16'(res / 65536);
                e_lat  = 2;
            end
            3'd5: begin
                if (ub == 0) begin
                    e_err = 1'b1;
                end else begin
                    mwrite(d, 16'(ua / ub));
                    m_sgpr = 16'(ua % ub);
                    e_lat  = 17;
                end
            end
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic peek(input logic [4:0] a);
        rd_addr = a;
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            #1;
            check(tag, {16'd0, rd_data}, {16'd0, m_gpr[i]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one instruction, wait (bounded) for done and check the outcome.
    // hold=1 keeps in_valid high while the unit is busy.
    task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic im, input logic [15:0] iv,
                         input logic hold);
        logic e_err;
        int   e_lat;
        int   lat;
        model_exec(o, d, s1, s2, im, iv, e_err, e_lat);
        @(negedge clk);
        check("ready_before_issue", {31'd0, in_ready}, 32'd1);
        op = o; rdst = d; rsrc1 = s1; rsrc2 = s2; imm_mode = im; imm = iv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid = 1'b0;
            op       = 3'($urandom_range(0, 7));
            rdst     = 5'($urandom_range(0, 31));
            rsrc1    = 5'($urandom_range(0, 31));
            rsrc2    = 5'($urandom_range(0, 31));
            imm_mode = 1'($urandom_range(0, 1));
            imm      = 16'($urandom_range(0, 65535));
        end
        @(negedge clk);
        check("busy_after_accept", {30'd0, in_ready, done}, 32'd0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            check("ready_low_while_busy", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("latency", lat, e_lat);
        check("err", {31'd0, err}, {31'd0, e_err});
        peek(d);
        check("rd_data_dst", {16'd0, rd_data}, {16'd0, m_gpr[d]});
        check("sgpr", {16'd0, sgpr}, {16'd0, m_sgpr});
        check("flags_cz", {30'd0, flag_c, flag_z}, {30'd0, m_c, m_z});
        @(negedge clk);
        check("done_single_pulse", {30'd0, in_ready, done}, 32'd2);
    endtask

    initial begin : main
        logic [2:0]  r_o;
        logic        r_im;
        logic [15:0] r_iv;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rdst = 5'd0; rsrc1 = 5'd0;
        rsrc2 = 5'd0; imm_mode = 1'b0; imm = 16'd0; rd_addr = 5'd0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_sgpr", {16'd0, sgpr}, 32'd0);
        check("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
        check_all("rst_gpr");

        // MOV imm then ADD register
        issue(3'd1, 5'd4, 5'd0, 5'd0, 1'b1, 16'd55, 1'b0);
        issue(3'd2, 5'd2, 5'd4, 5'd4, 1'b0, 16'd0, 1'b0);
        peek(5'd2);
        check("add_r2_110", {16'd0, rd_data}, 32'd110);
        check("add_flags", {30'd0, flag_c, flag_z}, 32'd0);

        // SUB with borrow, SUB imm to zero
        issue(3'd1, 5'd3, 5'd0, 5'd0, 1'b1, 16'd1, 1'b0);
        issue(3'd1, 5'd4, 5'd0, 5'd0, 1'b1, 16'd2, 1'b0);
        issue(3'd3, 5'd5, 5'd3, 5'd4, 1'b0, 16'd0, 1'b0);
        peek(5'd5);
        check("sub_r5_ffff", {16'd0, rd_data}, 32'h0000FFFF);
        check("sub_borrow", {31'd0, flag_c}, 32'd1);
        issue(3'd3, 5'd6, 5'd3, 5'd0, 1'b1, 16'd1, 1'b0);
        check("sub_zero_flag", {31'd0, flag_z}, 32'd1);

        // MUL and MOVSGPR
        issue(3'd1, 5'd6, 5'd0, 5'd0, 1'b1, 16'h1234, 1'b0);
        issue(3'd1, 5'd7, 5'd0, 5'd0, 1'b1, 16'h0100, 1'b0);
        issue(3'd4, 5'd8, 5'd6, 5'd7, 1'b0, 16'd0, 1'b0);
        peek(5'd8);
        check("mul_lo", {16'd0, rd_data}, 32'h3400);
        check("mul_hi", {16'd0, sgpr}, 32'h0012);
        issue(3'd0, 5'd9, 5'd0, 5'd0, 1'b0, 16'd0, 1'b0);
        peek(5'd9);
        check("movsgpr_r9", {16'd0, rd_data}, 32'h0012);

        // DIV imm and DIV by zero register
        issue(3'd1, 5'd9, 5'd0, 5'd0, 1'b1, 16'd5, 1'b0);
        issue(3'd5, 5'd11, 5'd9, 5'd0, 1'b1, 16'd2, 1'b0);
        peek(5'd11);
        check("div_quot", {16'd0, rd_data}, 32'd2);
        check("div_rem", {16'd0, sgpr}, 32'd1);
        issue(3'd5, 5'd11, 5'd9, 5'd0, 1'b0, 16'd0, 1'b0);
        peek(5'd11);
        check("div0_r11_kept", {16'd0, rd_data}, 32'd2);

        // Illegal opcodes leave all state alone
        issue(3'd6, 5'd2, 5'd3, 5'd4, 1'b1, 16'd7, 1'b0);
        issue(3'd7, 5'd5, 5'd3, 5'd4, 1'b0, 16'd7, 1'b0);
        check_all("illegal_gpr");

        // in_valid held high through a DIV: exactly one accept
        issue(3'd5, 5'd12, 5'd8, 5'd7, 1'b0, 16'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("hold_no_reaccept", {30'd0, in_ready, done}, 32'd2);
        end

        // Reset in the middle of a DIV aborts it with no writeback
        @(negedge clk);
        op = 3'd5; rdst = 5'd13; rsrc1 = 5'd8; rsrc2 = 5'd0; imm_mode = 1'b1; imm = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_busy_no_done", {30'd0, in_ready, done}, 32'd0);
        end
        do_reset();
        repeat (20) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, in_ready, done}, 32'd2);
        end
        check("abort_sgpr", {16'd0, sgpr}, 32'd0);
        check("abort_flags", {30'd0, flag_c, flag_z}, 32'd0);
        check_all("abort_gpr");

        // Random instructions against the model
        for (int n = 0; n < 60; n++) begin
            r_o  = 3'($urandom_range(0, 7));
            r_im = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_iv = 16'($urandom_range(0, 3));
            else                           r_iv = 16'($urandom_range(0, 65535));
            if (n < 8) r_o = 3'd1;
            if (n < 8) r_im = 1'b1;
            issue(r_o, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), r_im, r_iv, 1'($urandom_range(0, 1)));
        end
        check_all("final_gpr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
